// File: rtl/hex_instr_loader.sv
// hex_instr_loader: UART byte stream -> 32-bit instruction-memory words.
// Echoes every byte, decodes hex (MSN first), handles separators/resync/bad.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_en             decode enable (counters frozen when low)
//   rx_data/rx_valid    received byte and UART rdy
//   rx_clr              one-cycle rdy_clr pulse
//   tx_busy             transmitter busy, holds off byte acceptance
//   tx_data/tx_wr       echo byte and one-cycle strobe
//   im_we/im_addr/im_wdata  instruction-memory write port
//   word_cnt            words written since reset or resync
//   mem_full            sticky, DEPTH words written
//   bad_cnt             saturating rejected-character count
module hex_instr_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_clr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              mem_full,
  output logic [7:0]        bad_cnt
);

  typedef enum logic {
    IDLE,
    GUARD
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [2:0]        nib_idx;
  logic [31:0]       shreg;
  logic [ADDR_W-1:0] waddr;

  logic       is_dig;
  logic       is_alpha;
  logic       is_nib;
  logic       is_sep;
  logic       is_sync;
  logic [3:0] nib;
  logic [31:0] word_nxt;

  always_comb begin
    is_dig   = rx_data >= 8'h30 && rx_data <= 8'h39;
    // upper/lower hex letters share the low nibble 1..6
    is_alpha = (rx_data >= 8'h41 && rx_data <= 8'h46) ||
               (rx_data >= 8'h61 && rx_data <= 8'h66);
    is_nib   = is_dig || is_alpha;
    is_sep   = rx_data == 8'h0D || rx_data == 8'h0A ||
               rx_data == 8'h20 || rx_data == 8'h5F;
    is_sync  = rx_data == 8'h23;
    nib      = is_alpha ? rx_data[3:0] + 4'd9 : rx_data[3:0];
    word_nxt = {shreg[27:0], nib};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rx_clr   <= 1'b0;
      tx_wr    <= 1'b0;
      im_we    <= 1'b0;
      tx_data  <= '0;
      im_addr  <= '0;
      im_wdata <= '0;
      word_cnt <= '0;
      mem_full <= 1'b0;
      bad_cnt  <= '0;
      nib_idx  <= '0;
      shreg    <= '0;
      waddr    <= '0;
    end else begin
      rx_clr <= 1'b0;
      tx_wr  <= 1'b0;
      im_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid && !tx_busy) begin
            rx_clr  <= 1'b1;
            tx_wr   <= 1'b1;
            tx_data <= rx_data;
            state   <= GUARD;
            if (load_en) begin
              unique case (1'b1)
                is_nib: begin
                  shreg <= word_nxt;
                  if (nib_idx == 3'd7) begin
                    nib_idx <= '0;
                    if (!mem_full) begin
                      im_we    <= 1'b1;
                      im_wdata <= word_nxt;
                      im_addr  <= waddr;
                      word_cnt <= word_cnt + (ADDR_W+1)'(1);
                      // address saturates at the top word
                      if (waddr == LAST) mem_full <= 1'b1;
                      else waddr <= waddr + ADDR_W'(1);
                    end
                  end else begin
                    nib_idx <= nib_idx + 3'd1;
                  end
                end
                is_sync: begin
                  nib_idx  <= '0;
                  shreg    <= '0;
                  waddr    <= '0;
                  word_cnt <= '0;
                  mem_full <= 1'b0;
                end
                is_sep: begin
                end
                default: begin
                  if (bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
                  nib_idx <= '0;
                  shreg   <= '0;
                end
              endcase
            end
          end
        end
        GUARD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_instr_loader.sv
// tb_hex_instr_loader: randomized + directed bench for hex_instr_loader.
// Behavioural model tracks digits/words/counts; compare runs every cycle.
module tb_hex_instr_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              load_en;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_clr;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   word_cnt;
  logic              mem_full;
  logic [7:0]        bad_cnt;

  hex_instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_clr(rx_clr),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_wr(tx_wr),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .word_cnt(word_cnt), .mem_full(mem_full), .bad_cnt(bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_guard;
  int          m_ndig;
  logic [31:0] m_word;
  int          m_cnt;
  int          m_bad;
  logic        e_rx_clr, e_tx_wr, e_im_we;
  logic [7:0]  e_tx_data;
  int          e_im_addr;
  logic [31:0] e_im_wdata;

  function automatic int hexval(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 48 && v <= 57) return v - 48;
    if (v >= 65 && v <= 70) return v - 55;
    if (v >= 97 && v <= 102) return v - 87;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int h;
    h = hexval(b);
    if (h >= 0) begin
      m_word = m_word * 16 + h;
      m_ndig++;
      if (m_ndig == 8) begin
        if (m_cnt < DEPTH) begin
          e_im_we    = 1'b1;
          e_im_addr  = m_cnt;
          e_im_wdata = m_word;
          m_cnt++;
        end
        m_ndig = 0;
        m_word = 0;
      end
    end else if (b == 8'h0D || b == 8'h0A || b == 8'h20 || b == 8'h5F) begin
    end else if (b == 8'h23) begin
      m_ndig = 0;
      m_word = 0;
      m_cnt  = 0;
    end else begin
      if (m_bad < 255) m_bad++;
      m_ndig = 0;
      m_word = 0;
    end
  endtask

  always @(posedge clk) begin
    e_rx_clr = 1'b0;
    e_tx_wr  = 1'b0;
    e_im_we  = 1'b0;
    if (rst) begin
      e_tx_data = 0; e_im_addr = 0; e_im_wdata = 0;
      m_guard = 0; m_ndig = 0; m_word = 0; m_cnt = 0; m_bad = 0;
    end else if (m_guard) begin
      m_guard = 0;
    end else if (rx_valid && !tx_busy) begin
      m_guard   = 1;
      e_rx_clr  = 1'b1;
      e_tx_wr   = 1'b1;
      e_tx_data = rx_data;
      if (load_en) model_byte(rx_data);
    end
  end

  // ---------------- compare + write log ----------------
  int          wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_clr", 32'(rx_clr), 32'(e_rx_clr));
      chk("tx_wr", 32'(tx_wr), 32'(e_tx_wr));
      chk("im_we", 32'(im_we), 32'(e_im_we));
      chk("tx_data", 32'(tx_data), 32'(e_tx_data));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      chk("mem_full", 32'(mem_full), 32'(m_cnt == DEPTH));
      chk("bad_cnt", 32'(bad_cnt), 32'(m_bad));
      if (e_im_we) begin
        chk("im_addr", 32'(im_addr), 32'(e_im_addr));
        chk("im_wdata", im_wdata, e_im_wdata);
      end
      if (im_we) begin
        wa_q.push_back(int'(im_addr));
        wd_q.push_back(im_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input bit rb);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    tx_busy  = rb ? ($urandom_range(0, 2) == 0) : 1'b0;
    forever begin
      @(negedge clk);
      if (rx_clr) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no rx_clr expected rx_clr byte %h", b);
        break;
      end
      tx_busy = rb ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    rx_valid = 1'b0;
    tx_busy  = rb ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic send_str(input string s, input bit rb);
    for (int i = 0; i < s.len(); i++) send(s[i], rb);
  endtask

  task automatic settle();
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    int r;
    logic [7:0] b;
    string hx;
    hx = "0123456789abcdefABCDEF";
    rst = 1'b1; load_en = 1'b1; rx_data = 8'h00;
    rx_valid = 1'b0; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_im_we", 32'(im_we), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_bad_cnt", 32'(bad_cnt), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    rst = 1'b0;

    // 1: single word
    clr_log();
    send_str("DEADBEEF", 1);
    settle();
    chk("t1_nwr", wa_q.size(), 1);
    chk("t1_addr", wa_q[0], 0);
    chk("t1_data", wd_q[0], 32'hDEADBEEF);
    chk("t1_cnt", 32'(word_cnt), 1);

    // 2: separators and lowercase
    clr_log();
    send_str("#00a00093\r\n00100113", 1);
    settle();
    chk("t2_nwr", wa_q.size(), 2);
    chk("t2_d0", wd_q[0], 32'h00A00093);
    chk("t2_a1", wa_q[1], 1);
    chk("t2_d1", wd_q[1], 32'h00100113);
    chk("t2_bad", 32'(bad_cnt), 0);

    // 3: bad char discards partial word
    clr_log();
    send_str("#123G45678901", 1);
    settle();
    chk("t3_bad", 32'(bad_cnt), 1);
    chk("t3_nwr", wa_q.size(), 1);
    chk("t3_addr", wa_q[0], 0);
    chk("t3_data", wd_q[0], 32'h45678901);

    // 4: fill, overflow, resync
    clr_log();
    send(8'h23, 1);
    for (int k = 0; k < 17; k++) send_str("FFFFFFFF", 1);
    settle();
    chk("t4_nwr", wa_q.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk("t4_addr", wa_q[k], k);
      chk("t4_data", wd_q[k], 32'hFFFFFFFF);
    end
    chk("t4_full", 32'(mem_full), 1);
    chk("t4_cnt", 32'(word_cnt), 16);
    clr_log();
    send_str("#00000013", 1);
    settle();
    chk("t4r_nwr", wa_q.size(), 1);
    chk("t4r_addr", wa_q[0], 0);
    chk("t4r_data", wd_q[0], 32'h00000013);
    chk("t4r_full", 32'(mem_full), 0);

    // 5: tx_busy holds the byte pending
    @(negedge clk);
    rx_data = 8'h5F; rx_valid = 1'b1; tx_busy = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("t5_hold_clr", 32'(rx_clr), 0);
      chk("t5_hold_wr", 32'(tx_wr), 0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t5_clr", 32'(rx_clr), 1);
    chk("t5_wr", 32'(tx_wr), 1);
    chk("t5_echo", 32'(tx_data), 32'h5F);
    @(negedge clk);
    chk("t5_guard", 32'(rx_clr), 0);
    rx_valid = 1'b0;
    settle();

    // 6: reset mid-word, then load_en low
    clr_log();
    send_str("ABCD", 1);
    pulse_rst();
    send_str("12345678", 1);
    settle();
    chk("t6_nwr", wa_q.size(), 1);
    chk("t6_addr", wa_q[0], 0);
    chk("t6_data", wd_q[0], 32'h12345678);
    clr_log();
    load_en = 1'b0;
    send_str("11111111", 1);
    settle();
    chk("t6_off_nwr", wa_q.size(), 0);
    chk("t6_off_cnt", 32'(word_cnt), 1);
    load_en = 1'b1;

    // bad_cnt saturation
    for (int k = 0; k < 260; k++) send(8'h21, 0);
    settle();
    chk("sat_bad", 32'(bad_cnt), 255);

    // randomized traffic
    pulse_rst();
    for (int k = 0; k < 700; k++) begin
      r = $urandom_range(0, 255);
      if (r < 180) b = hx[$urandom_range(0, 21)];
      else if (r < 210) b = (r[1:0] == 0) ? 8'h0D : (r[1:0] == 1) ? 8'h0A :
                            (r[1:0] == 2) ? 8'h20 : 8'h5F;
      else if (r < 212) b = 8'h23;
      else if (r < 235) b = 8'($urandom_range(0, 255));
      else begin
        load_en = ($urandom_range(0, 3) != 0);
        b = hx[$urandom_range(0, 21)];
      end
      if (r == 255) pulse_rst();
      send(b, 1);
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
